// File: rtl/address_mux_pkg.sv
// Shared definitions for the memory-address selector: source-select encodings.
package address_mux_pkg;

  // Which requester owns the shared memory port this cycle.
  typedef enum logic {
    SRC_INST = 1'b0,  // instruction fetch (PC path)
    SRC_OP   = 1'b1   // load/store operand address
  } src_e;

endpackage : address_mux_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step only when enabled and not already saturated.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/address_mux.sv
// Shared-memory address selector: picks PC or operand address combinationally
// and keeps registered bookkeeping (address, source, switch pulse, data-access count).
module address_mux
  import address_mux_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2 ** WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inst_addr,
  input  logic [WIDTH-1:0] op_addr,
  input  logic             sel,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] addr_q,
  output logic             src_q,
  output logic             switch_p,
  output logic             oob,
  output logic [CNT_W-1:0] op_cnt
);

  // Compare at WIDTH+1 bits so DEPTH == 2**WIDTH is representable.
  localparam logic [WIDTH:0] DEPTH_EXT = (WIDTH + 1)'(DEPTH);

  src_e             sel_src;
  logic [WIDTH-1:0] addr_d;
  logic             src_d;
  logic             switch_d;

  assign sel_src = src_e'(sel);

  // Zero-latency address select; valid regardless of reset.
  assign addr = (sel_src == SRC_OP) ? op_addr : inst_addr;

  // Range flag; folds to constant 0 when DEPTH covers the whole address space.
  assign oob = ({1'b0, addr} >= DEPTH_EXT);

  // Next-state values for the bookkeeping registers.
  always_comb begin
    addr_d   = addr;
    src_d    = sel;
    switch_d = (sel != src_q);
  end

  // Bookkeeping registers; reset forces the instruction source and clears the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      src_q    <= SRC_INST;
      switch_p <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      src_q    <= src_d;
      switch_p <= switch_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_op_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(sel_src == SRC_OP),
    .cnt_o(op_cnt)
  );

endmodule : address_mux

// File: tb/tb_address_mux.sv
// Self-checking bench for address_mux: default instance plus a small instance
// (DEPTH=20, CNT_W=3) driven by the same inputs, checked against a behavioural model.
module tb_address_mux;

  localparam int W      = 5;
  localparam int S_DEP  = 20;
  localparam int S_CNTW = 3;
  localparam int D_MAX  = 255;
  localparam int S_MAX  = 7;

  logic         clk;
  logic         rst;
  logic [W-1:0] inst_addr;
  logic [W-1:0] op_addr;
  logic         sel;

  logic [W-1:0] d_addr, d_addr_q, s_addr, s_addr_q;
  logic         d_src_q, d_switch_p, d_oob, s_src_q, s_switch_p, s_oob;
  logic [7:0]   d_op_cnt;
  logic [2:0]   s_op_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  address_mux u_dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .op_addr(op_addr), .sel(sel),
    .addr(d_addr), .addr_q(d_addr_q), .src_q(d_src_q), .switch_p(d_switch_p),
    .oob(d_oob), .op_cnt(d_op_cnt)
  );

  address_mux #(.WIDTH(W), .DEPTH(S_DEP), .CNT_W(S_CNTW)) u_dut_s (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .op_addr(op_addr), .sel(sel),
    .addr(s_addr), .addr_q(s_addr_q), .src_q(s_src_q), .switch_p(s_switch_p),
    .oob(s_oob), .op_cnt(s_op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: previous selected address/source, and the number of
  // sel=1 cycles since reset (the counters are that number clipped to their max).
  logic [W-1:0] m_addr_q;
  logic         m_src_q;
  logic         m_switch;
  int           m_ops;

  always @(posedge clk) begin
    if (rst) begin
      m_addr_q <= '0;
      m_src_q  <= 1'b0;
      m_switch <= 1'b0;
      m_ops    <= 0;
    end else begin
      m_addr_q <= sel ? op_addr : inst_addr;
      m_src_q  <= sel;
      m_switch <= (sel != m_src_q);
      m_ops    <= m_ops + (sel ? 1 : 0);
    end
  end

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare process: every cycle once reset has been applied.
  always @(negedge clk) begin
    if (chk_en) begin
      int exp_addr;
      exp_addr = sel ? int'(op_addr) : int'(inst_addr);
      check("d_addr",   32'(d_addr),     32'(exp_addr));
      check("s_addr",   32'(s_addr),     32'(exp_addr));
      check("d_oob",    32'(d_oob),      32'(exp_addr >= 32));
      check("s_oob",    32'(s_oob),      32'(exp_addr >= S_DEP));
      check("d_addr_q", 32'(d_addr_q),   32'(m_addr_q));
      check("s_addr_q", 32'(s_addr_q),   32'(m_addr_q));
      check("d_src_q",  32'(d_src_q),    32'(m_src_q));
      check("s_src_q",  32'(s_src_q),    32'(m_src_q));
      check("d_switch", 32'(d_switch_p), 32'(m_switch));
      check("s_switch", 32'(s_switch_p), 32'(m_switch));
      check("d_op_cnt", 32'(d_op_cnt),   32'(clip(m_ops, D_MAX)));
      check("s_op_cnt", 32'(s_op_cnt),   32'(clip(m_ops, S_MAX)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] prev_addr;

    // Combinational select, valid while reset is held.
    rst = 1'b1; sel = 1'b0; inst_addr = 5'b10000; op_addr = 5'b11111;
    #1;
    check("lit_addr_sel0", 32'(d_addr), 32'd16);
    sel = 1'b1;
    #1;
    check("lit_addr_sel1", 32'(d_addr), 32'd31);
    sel = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;

    // Registered path and switch pulse.
    rst = 1'b0;
    repeat (3) tick();
    check("lit_addr_q_inst", 32'(d_addr_q),   32'd16);
    check("lit_src_q_inst",  32'(d_src_q),    32'd0);
    check("lit_sw_idle",     32'(d_switch_p), 32'd0);
    sel = 1'b1;
    tick();
    check("lit_addr_q_op",   32'(d_addr_q),   32'd31);
    check("lit_src_q_op",    32'(d_src_q),    32'd1);
    check("lit_sw_pulse",    32'(d_switch_p), 32'd1);
    tick();
    check("lit_sw_drop",     32'(d_switch_p), 32'd0);
    repeat (3) tick();
    check("lit_cnt5",        32'(s_op_cnt),   32'd5);

    // Reset mid-operation with sel=1 and op_cnt=5.
    rst = 1'b1;
    tick();
    check("lit_rst_addr_q",  32'(d_addr_q),   32'd0);
    check("lit_rst_src_q",   32'(d_src_q),    32'd0);
    check("lit_rst_cnt",     32'(d_op_cnt),   32'd0);
    check("lit_rst_sw",      32'(d_switch_p), 32'd0);
    check("lit_rst_addr",    32'(d_addr),     32'd31);
    rst = 1'b0;

    // Saturation: first edge after reset with sel=1 also pulses switch_p.
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("lit_sat_small", 32'(s_op_cnt), 32'((i > 7) ? 7 : i));
      check("lit_sat_big",   32'(d_op_cnt), 32'(i));
      if (i == 1) check("lit_first_sw", 32'(d_switch_p), 32'd1);
    end
    sel = 1'b0;
    tick();
    check("lit_sat_hold", 32'(s_op_cnt), 32'd7);
    check("lit_big_hold", 32'(d_op_cnt), 32'd10);

    // Range flag on the DEPTH=20 instance.
    op_addr = 5'd19; sel = 1'b1;
    #1;
    check("lit_oob_19", 32'(s_oob), 32'd0);
    op_addr = 5'd20;
    #1;
    check("lit_oob_20", 32'(s_oob), 32'd1);
    check("lit_oob_def", 32'(d_oob), 32'd0);
    inst_addr = 5'd3; sel = 1'b0;
    #1;
    check("lit_oob_inst3", 32'(s_oob), 32'd0);
    tick();

    // Equal addresses still pulse on a source change.
    inst_addr = 5'd7; op_addr = 5'd7; sel = 1'b1;
    tick();
    check("lit_eq_sw", 32'(d_switch_p), 32'd1);
    check("lit_eq_addr_q", 32'(d_addr_q), 32'd7);

    // Toggle stress with random addresses.
    for (int i = 0; i < 8; i++) begin
      sel       = ~sel;
      inst_addr = W'($urandom_range(31, 0));
      op_addr   = W'($urandom_range(31, 0));
      prev_addr = sel ? op_addr : inst_addr;
      tick();
      check("lit_tog_sw",     32'(d_switch_p), 32'd1);
      check("lit_tog_addr_q", 32'(d_addr_q),   32'(prev_addr));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_address_mux
